mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter and sequencer for the 64 x 32 single-port test memory. It accepts independent read/write requests from two masters (A and B), serialises them onto the memory's cs / rw_ / adder / datain pins and captures the tri-stated dataout into a per-port read register. It sits between the two bus masters and the memory, and is the only driver of the memory's control pins.

## Interface

Parameters:
- AW, 6, address width; matches the 64-word memory.
- DW, 32, data width.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A 1 = write, 0 = read; stable while a_req.
- a_addr  in  AW  port A word address; stable while a_req.
- a_wdata  in  DW  port A write data; stable while a_req.
- a_ack  out  1  one-cycle completion pulse to A.
- a_rdata  out  DW  port A read data; valid from a_ack until A's next read completes.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- mem_cs  out  1  memory chip select, registered.
- mem_rw_  out  1  memory 1 = read, 0 = write, registered.
- mem_adder  out  AW  memory address, registered.
- mem_datain  out  DW  memory write data, registered.
- mem_dataout  in  DW  memory read data; high-Z unless a read is selected.

## Operation

- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any req is high, choose the winner, load the mem_* registers from the winner's port, set mem_cs=1, and go to ACCESS. If no req is high, stay in IDLE with mem_cs=0.
- Arbitration: round-robin using a last_grant flag.
  - A lone requester always wins.
  - With simultaneous requests, the port not in last_grant wins.
  - last_grant updates on every grant.
  - Reset value of last_grant is B, so A wins the first tie.
- ACCESS, one cycle, mem_cs=1:
  - Write (mem_rw_=0): the memory writes at the closing edge.
  - Read (mem_rw_=1): mem_dataout is sampled at the closing edge into the winner's rdata register. The other port's rdata is unchanged.
  - Transition to ACK; mem_cs and mem_rw_ return to 0 and 1 on entry to ACK.
- ACK, one cycle: the winner's ack=1, then go to IDLE.
  - The requester must drop req at the edge where it samples ack.
  - A req still high in IDLE is treated as a new request.
- Writes never update either rdata register.
- mem_dataout is ignored outside ACCESS. Its high-Z value is never captured.
- The memory's own reset pin is not driven by this block.

## Timing

- Reset values:
  - state=IDLE, mem_cs=0, mem_rw_=1, mem_adder=0, mem_datain=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, last_grant=B.
- Latency: req seen high at edge N, then mem_cs=1 during cycle N+1, then ack=1 and rdata valid during cycle N+2.
- Throughput: one access per 3 cycles. Back-to-back requests from alternating ports complete every 3 cycles.
- mem_* outputs change only at clock edges (glitch-free), except at reset assertion.
- Reset assertion in ACCESS: mem_cs clears immediately, so no write occurs at the next edge. Any pending request is dropped with no ack and must be re-issued after reset release.
- Reset assertion in ACK: the ack is lost; rdata clears to 0.
- A req asserted during ACCESS or ACK waits and is evaluated in the next IDLE cycle.
- While one port is being served, the loser of a tie keeps req high. It is granted in the next IDLE cycle, even if the winner has re-requested.

## Test plan

- Reset: hold reset=0 with random inputs. Required: all outputs at their reset values and mem_cs never 1. Release reset with no req: mem_cs stays 0.
- Single write then read:
  - A writes 0xDEADBEEF to address 5: a_ack 2 cycles after the req edge, with mem_cs=1, mem_rw_=0, mem_adder=5 during ACCESS.
  - A then reads address 5: a_rdata=0xDEADBEEF when a_ack=1.
- Simultaneous requests:
  - A and B both request from reset: A is granted first; B's ack comes 3 cycles after A's ack.
  - Repeat with both holding req: grants alternate A, B, A, B.
- Port isolation: B reads address 63 holding 0x12345678 while A's a_rdata holds 0xCAFEF00D. Required: b_rdata=0x12345678 and a_rdata unchanged.
- Reset mid-access: assert reset in the ACCESS cycle of a write of 0x0 to address 7, which previously held 0xAAAAAAAA. After release, a read of address 7 returns 0xAAAAAAAA, and no ack was issued for the aborted write.
- Boundaries: write then read addresses 0 and 63 with 0xFFFFFFFF and 0x00000001. Required: exact readback, and mem_adder never exceeds 63.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 64 x 32 single-port test memory.
// Each granted access takes three cycles: IDLE (grant) -> ACCESS (mem_cs high) -> ACK.
module mem_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,

    output logic          mem_cs,
    output logic          mem_rw_,
    output logic [AW-1:0] mem_adder,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;   // 1 = port B, also names the port being served
    logic          cs_q, cs_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          win_b;

    // B wins when alone, or on a tie when A was served last.
    always_comb begin
        win_b = b_req & (~a_req | ~last_grant_q);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cs_d         = cs_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d      = ACCESS;
                    last_grant_d = win_b;
                    cs_d         = 1'b1;
                    rw_d         = win_b ? ~b_we    : ~a_we;
                    addr_d       = win_b ? b_addr   : a_addr;
                    wdata_d      = win_b ? b_wdata  : a_wdata;
                end
            end
            ACCESS: begin
                state_d = ACK;
                cs_d    = 1'b0;
                rw_d    = 1'b1;
                // mem_dataout is only driven here, and only for reads.
                if (rw_q) begin
                    if (last_grant_q) b_rdata_d = mem_dataout;
                    else              a_rdata_d = mem_dataout;
                end
                if (last_grant_q) b_ack_d = 1'b1;
                else              a_ack_d = 1'b1;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cs_q         <= 1'b0;
            rw_q         <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cs_q         <= cs_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign mem_cs     = cs_q;
    assign mem_rw_    = rw_q;
    assign mem_adder  = addr_q;
    assign mem_datain = wdata_q;
    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences, and a
// randomized two-master run against a transaction-level model with a shadow memory.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_cs, mem_rw_;
    logic [AW-1:0] mem_adder;
    logic [DW-1:0] mem_datain;
    wire  [DW-1:0] mem_dataout;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_cs(mem_cs), .mem_rw_(mem_rw_), .mem_adder(mem_adder),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    // The 64 x 32 test memory: writes at the edge, tri-stated read port.
    logic [DW-1:0] mem_arr [64];
    always @(posedge clk) if (mem_cs && !mem_rw_) mem_arr[mem_adder] <= mem_datain;
    assign mem_dataout = (mem_cs && mem_rw_) ? mem_arr[mem_adder] : {DW{1'bz}};

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] shadow [64];
    logic [DW-1:0] m_a_rd, m_b_rd;
    bit            m_last;

    typedef struct {
        bit            p;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input bit p, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        if (p) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else   begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        step();
        chk("txn_cs", mem_cs, 1);
        chk("txn_rw", mem_rw_, !we);
        chk("txn_addr", mem_adder, addr);
        if (we) chk("txn_din", mem_datain, wd);
        chk("txn_early_ack", {a_ack, b_ack}, 0);
        step();
        chk("txn_ack", {a_ack, b_ack}, p ? 2'b01 : 2'b10);
        chk("txn_cs_ack", {mem_cs, mem_rw_}, 2'b01);
        if (we) shadow[addr] = wd;
        else if (p) m_b_rd = exp_rd;
        else m_a_rd = exp_rd;
        chk("txn_a_rdata", a_rdata, m_a_rd);
        chk("txn_b_rdata", b_rdata, m_b_rd);
        a_req = 0; b_req = 0;
        step();
        chk("txn_ack_clear", {a_ack, b_ack}, 0);
        m_last = p;
    endtask

    int cyc, grant_e, ack_e, free_e, a_c, b_c, nack, last_c;
    bit g_port, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, g_rd;

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        tbl[0] = '{0, 1, 6'd5,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 0, 6'd5,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{0, 1, 6'd10, 32'hCAFEF00D, 32'h0};
        tbl[3] = '{0, 0, 6'd10, 32'h0,        32'hCAFEF00D};
        tbl[4] = '{1, 1, 6'd63, 32'h12345678, 32'h0};
        tbl[5] = '{1, 0, 6'd63, 32'h0,        32'h12345678};
        tbl[6] = '{0, 1, 6'd0,  32'hFFFFFFFF, 32'h0};
        tbl[7] = '{1, 1, 6'd63, 32'h00000001, 32'h0};
        tbl[8] = '{1, 0, 6'd0,  32'h0,        32'hFFFFFFFF};
        tbl[9] = '{0, 0, 6'd63, 32'h0,        32'h00000001};

        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        m_a_rd = '0; m_b_rd = '0; m_last = 1;
        reset = 1;
        #2 reset = 0;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            a_req = 1'($urandom); a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = $urandom;
            b_req = 1'($urandom); b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = $urandom;
            step();
            chk("rst_ctrl", {mem_cs, mem_rw_, a_ack, b_ack}, 4'b0100);
            chk("rst_adder", mem_adder, 0);
            chk("rst_datain", mem_datain, 0);
            chk("rst_rdata", {a_rdata, b_rdata}, 0);
        end
        a_req = 0; b_req = 0;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_cs", mem_cs, 0);
        end

        // Simultaneous writes from reset: A first, B three cycles later
        a_req = 1; a_we = 1; a_addr = 6'd7; a_wdata = 32'hAAAAAAAA;
        b_req = 1; b_we = 1; b_addr = 6'd8; b_wdata = 32'h55555555;
        a_c = 0; b_c = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (a_ack) begin if (a_c == 0) a_c = c; a_req = 0; end
            if (b_ack) begin if (b_c == 0) b_c = c; b_req = 0; end
        end
        chk("sim_a_ack_cyc", a_c, 2);
        chk("sim_b_ack_cyc", b_c, 5);
        shadow[7] = 32'hAAAAAAAA; shadow[8] = 32'h55555555; m_last = 1;

        // Both ports holding req: grants alternate A, B, A, B
        a_req = 1; a_we = 0; a_addr = 6'd7;
        b_req = 1; b_we = 0; b_addr = 6'd8;
        nack = 0; last_c = 0;
        for (int c = 1; c <= 30 && nack < 4; c++) begin
            step();
            if (a_ack || b_ack) begin
                chk("alt_order", {a_ack, b_ack}, (nack % 2) ? 2'b01 : 2'b10);
                if (nack > 0) chk("alt_gap", c - last_c, 3);
                last_c = c;
                if (a_ack) begin chk("alt_a_rdata", a_rdata, 32'hAAAAAAAA); a_req = 0; end
                if (b_ack) begin chk("alt_b_rdata", b_rdata, 32'h55555555); b_req = 0; end
                nack++;
            end else begin
                a_req = 1; b_req = 1;
            end
        end
        chk("alt_count", nack, 4);
        a_req = 0; b_req = 0;
        step(); step();
        m_a_rd = 32'hAAAAAAAA; m_b_rd = 32'h55555555; m_last = 1;

        for (int i = 0; i < 10; i++)
            do_txn(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);

        // Reset asserted during the ACCESS cycle of a write to address 7
        a_req = 1; a_we = 1; a_addr = 6'd7; a_wdata = 32'h0;
        step();
        chk("abort_cs_before", mem_cs, 1);
        reset = 0;
        #1;
        chk("abort_cs_async", mem_cs, 0);
        a_req = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_no_ack_rst", {a_ack, b_ack, mem_cs}, 0);
        end
        reset = 1;
        m_a_rd = '0; m_b_rd = '0; m_last = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_no_ack", {a_ack, b_ack}, 0);
            chk("abort_rdata", {a_rdata, b_rdata}, 0);
        end
        do_txn(0, 0, 6'd7, 32'h0, 32'hAAAAAAAA);

        // Fill memory, then run two random masters against the model
        for (int i = 0; i < 64; i++) do_txn(i[0], 1, i[5:0], $urandom, 32'h0);

        cyc = 0; free_e = 0; grant_e = -1; ack_e = -1;
        for (int it = 0; it < 1500; it++) begin
            if (cyc + 1 >= free_e && (a_req || b_req)) begin
                g_port  = (a_req && b_req) ? !m_last : b_req;
                m_last  = g_port;
                g_we    = g_port ? b_we    : a_we;
                g_addr  = g_port ? b_addr  : a_addr;
                g_wdata = g_port ? b_wdata : a_wdata;
                grant_e = cyc + 1;
                ack_e   = cyc + 2;
                free_e  = cyc + 4;
                if (g_we) shadow[g_addr] = g_wdata;
                else      g_rd = shadow[g_addr];
            end
            step();
            cyc++;
            chk("rnd_cs", mem_cs, cyc == grant_e);
            if (cyc == grant_e) begin
                chk("rnd_rw", mem_rw_, !g_we);
                chk("rnd_addr", mem_adder, g_addr);
                if (g_we) chk("rnd_din", mem_datain, g_wdata);
            end
            chk("rnd_a_ack", a_ack, cyc == ack_e && !g_port);
            chk("rnd_b_ack", b_ack, cyc == ack_e && g_port);
            if (cyc == ack_e && !g_we) begin
                if (g_port) m_b_rd = g_rd;
                else        m_a_rd = g_rd;
            end
            chk("rnd_a_rdata", a_rdata, m_a_rd);
            chk("rnd_b_rdata", b_rdata, m_b_rd);
            if (cyc == ack_e) begin
                if (g_port) b_req = 0;
                else        a_req = 0;
            end else begin
                if (!a_req && $urandom_range(0, 2) == 0) begin
                    a_req = 1; a_we = 1'($urandom); a_addr = pick_addr(); a_wdata = $urandom;
                end
                if (!b_req && $urandom_range(0, 2) == 0) begin
                    b_req = 1; b_we = 1'($urandom); b_addr = pick_addr(); b_wdata = $urandom;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
